// File: rtl/brew_pkg.sv
// brew_pkg: shared status-code encoding, timer state type and helpers for brew_timer.
package brew_pkg;

    typedef enum logic [2:0] {
        STANDBY       = 3'b000,
        WORKING       = 3'b001,
        POURINGCOFFEE = 3'b010,
        POURINGMILK   = 3'b011,
        NEEDMILK      = 3'b100,
        DONE          = 3'b101,
        ENJOY         = 3'b110,
        ILLEGAL       = 3'b111
    } th_code_t;

    typedef enum logic [1:0] {IDLE, COUNTING, FIRED} timer_state_t;

    function automatic logic is_timed(th_code_t c);
        return c inside {WORKING, POURINGCOFFEE, POURINGMILK, ENJOY};
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/brew_interval_cnt.sv
// brew_interval_cnt: loadable saturating up-counter; done flags the edge on which the count lands on limit.
module brew_interval_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;
    logic [W-1:0] nxt;

    always_comb nxt = clr ? '0 : load ? W'(1) : (en && count != '1) ? count + 1'b1 : count;

    // A count already sitting on limit must not report done again.
    assign done = !clr && (load || (en && count != limit)) && nxt == limit;

    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else        count <= nxt;

endmodule

// File: rtl/brew_timer.sv
// brew_timer: times the phases reported on TH_M, answers with a one-cycle T pulse and drives the actuators.
// Optional watchdog enabled by defining BREW_WDT_EN.
module brew_timer
    import brew_pkg::*;
#(
    parameter int HEAT_CYC   = 8,
    parameter int COFFEE_CYC = 12,
    parameter int MILK_CYC   = 6,
    parameter int ENJOY_CYC  = 4,
    parameter int WDT_CYC    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] TH_M,
    output logic       T,
    output logic       heater,
    output logic       pump_cafe,
    output logic       pump_leche,
    output logic       need_milk,
    output logic       busy,
    output logic       err,
    output logic       fault
);

    localparam int MAX_CYC = max2(max2(HEAT_CYC, COFFEE_CYC), max2(MILK_CYC, ENJOY_CYC));
    localparam int W       = $clog2(MAX_CYC) + 1;

    if (HEAT_CYC < 1 || COFFEE_CYC < 1 || MILK_CYC < 1 || ENJOY_CYC < 1 || WDT_CYC < 1) begin : g_bad_cfg
        $error("brew_timer: every duration parameter must be at least 1");
    end

    th_code_t     code;
    th_code_t     prev_code;
    timer_state_t state;
    timer_state_t state_n;
    logic         change;
    logic         timed;
    logic         done;
    logic [W-1:0] limit;
    logic         heat_q;
    logic         cafe_q;
    logic         leche_q;

    assign code   = th_code_t'(TH_M);
    assign change = code != prev_code;
    assign timed  = is_timed(code);
    assign busy   = state == COUNTING;

    // Untimed codes never load or enable the counter, so their limit is don't-care.
    always_comb limit = (code == WORKING)       ? W'(HEAT_CYC)   :
                        (code == POURINGCOFFEE) ? W'(COFFEE_CYC) :
                        (code == POURINGMILK)   ? W'(MILK_CYC)   : W'(ENJOY_CYC);

    brew_interval_cnt #(.W(W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .load  (change && timed),
        .clr   (change && !timed),
        .en    (!change && state == COUNTING),
        .limit (limit),
        .done  (done)
    );

    always_comb state_n = (change && !timed) ? IDLE : done ? FIRED : change ? COUNTING : state;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            prev_code <= STANDBY;
            T         <= 1'b0;
            heat_q    <= 1'b0;
            cafe_q    <= 1'b0;
            leche_q   <= 1'b0;
            need_milk <= 1'b0;
            err       <= 1'b0;
        end else begin
            prev_code <= code;
            T         <= done;
            heat_q    <= code == WORKING;
            cafe_q    <= code == POURINGCOFFEE;
            leche_q   <= code == POURINGMILK;
            need_milk <= code == NEEDMILK;
            err       <= err || code == ILLEGAL;
        end

`ifdef BREW_WDT_EN
    localparam int WW = $clog2(WDT_CYC) + 1;
    logic wdt_done;
    logic fault_q;
    // Any non-STANDBY code held unchanged for WDT_CYC cycles trips the watchdog.
    brew_interval_cnt #(.W(WW)) u_wdt (
        .clk   (clk),
        .reset (reset),
        .load  (change && code != STANDBY),
        .clr   (code == STANDBY),
        .en    (!change && code != STANDBY),
        .limit (WW'(WDT_CYC)),
        .done  (wdt_done)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= fault_q || wdt_done;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign heater     = heat_q  && !fault;
    assign pump_cafe  = cafe_q  && !fault;
    assign pump_leche = leche_q && !fault;

endmodule
